// File: rtl/ay8_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ay8_pkg : shared ay8 core types (opcodes, micro-op, decode state)
// Rev 1.0
// ----------------------------------------------------------------------------
package ay8_pkg;

  localparam int AY8_DATA_W = 8;
  localparam int AY8_REG_AW = 2;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_MOV   = 4'h1,
    OP_ADD   = 4'h2,
    OP_SUB   = 4'h3,
    OP_AND   = 4'h4,
    OP_OR    = 4'h5,
    OP_LDI   = 4'h6,
    OP_JMP   = 4'h7,
    OP_JZ    = 4'h8,
    OP_LD    = 4'h9,
    OP_ST    = 4'hA,
    OP_ILL_B = 4'hB,
    OP_ILL_C = 4'hC,
    OP_ILL_D = 4'hD,
    OP_ILL_E = 4'hE,
    OP_HLT   = 4'hF
  } opcode_t;

  typedef struct packed {
    opcode_t                op;
    logic [AY8_REG_AW-1:0]  rd;
    logic [AY8_REG_AW-1:0]  rs;
    logic [AY8_DATA_W-1:0]  imm;
    logic [AY8_DATA_W-1:0]  pc;
    logic                   illegal;
  } uop_t;

  typedef enum logic [0:0] {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } dec_state_t;

  function automatic logic is_two_byte(opcode_t op);
    return (op == OP_LDI) || (op == OP_JMP) || (op == OP_JZ);
  endfunction

  function automatic logic is_legal(opcode_t op);
    return !((op == OP_ILL_B) || (op == OP_ILL_C) ||
             (op == OP_ILL_D) || (op == OP_ILL_E));
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// decode_stage_if : fetch-byte input and micro-op output handshakes of decode
// Rev 1.0
// ----------------------------------------------------------------------------
interface decode_stage_if #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_byte;
  logic [DATA_W-1:0] in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_op;
  logic [REG_AW-1:0] out_rd;
  logic [REG_AW-1:0] out_rs;
  logic [DATA_W-1:0] out_imm;
  logic [DATA_W-1:0] out_pc;
  logic              out_illegal;

  // Decode stage side
  modport slave (
    input  in_valid, in_byte, in_pc, out_ready,
    output in_ready, out_valid, out_op, out_rd, out_rs, out_imm, out_pc, out_illegal
  );

  // Fetch / execute side
  modport master (
    output in_valid, in_byte, in_pc, out_ready,
    input  in_ready, out_valid, out_op, out_rd, out_rs, out_imm, out_pc, out_illegal
  );
endinterface
`default_nettype wire

// File: rtl/decode_uop_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// decode_uop_reg : valid/ready output register holding one payload word
// Rev 1.0
// ----------------------------------------------------------------------------
module decode_uop_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Upstream only loads when the slot is empty or draining this cycle,
  // so a load never overwrites a payload that is still being held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// decode_stage : ay8 decode - assembles 1/2-byte instructions into micro-ops
// Rev 1.0
// ----------------------------------------------------------------------------
module decode_stage
  import ay8_pkg::*;
#(
  parameter int DATA_W = AY8_DATA_W,
  parameter int REG_AW = AY8_REG_AW
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           flush,
  output logic           halted,
  decode_stage_if.slave  bus
);

  dec_state_t         r_state;
  dec_state_t         w_state_next;
  opcode_t            r_hold_op;
  logic [REG_AW-1:0]  r_hold_rd;
  logic [REG_AW-1:0]  r_hold_rs;
  logic [DATA_W-1:0]  r_hold_pc;
  logic               r_halted;

  opcode_t            w_op;
  logic [REG_AW-1:0]  w_rd;
  logic [REG_AW-1:0]  w_rs;
  logic               w_in_ready;
  logic               w_in_xfer;
  logic               w_out_valid;
  logic               w_out_xfer;
  logic               w_hlt_pending;
  logic               w_load;
  logic               w_hold_load;
  uop_t               w_load_uop;
  uop_t               w_out_uop;

  assign w_op = opcode_t'(bus.in_byte[7:4]);
  assign w_rd = bus.in_byte[3:2];
  assign w_rs = bus.in_byte[1:0];

  // A pending HLT blocks intake so nothing follows it into execute.
  assign w_out_xfer    = w_out_valid && bus.out_ready;
  assign w_hlt_pending = w_out_valid && (w_out_uop.op == OP_HLT);
  assign w_in_ready    = !RST && !flush && !r_halted && !w_hlt_pending &&
                         (!w_out_valid || bus.out_ready);
  assign w_in_xfer     = bus.in_valid && w_in_ready;

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_hold_load  = 1'b0;
    w_load_uop   = '0;
    case (r_state)
      S_OP: begin
        if (w_in_xfer) begin
          if (is_two_byte(w_op)) begin
            w_hold_load  = 1'b1;
            w_state_next = S_IMM;
          end else begin
            w_load             = 1'b1;
            w_load_uop.op      = w_op;
            w_load_uop.rd      = w_rd;
            w_load_uop.rs      = w_rs;
            w_load_uop.pc      = bus.in_pc;
            w_load_uop.illegal = !is_legal(w_op);
          end
        end
      end
      S_IMM: begin
        if (w_in_xfer) begin
          w_load         = 1'b1;
          w_load_uop.op  = r_hold_op;
          w_load_uop.rd  = r_hold_rd;
          w_load_uop.rs  = r_hold_rs;
          w_load_uop.imm = bus.in_byte;
          w_load_uop.pc  = r_hold_pc;
          w_state_next   = S_OP;
        end
      end
      default: w_state_next = S_OP;
    endcase
    if (flush) begin
      w_state_next = S_OP;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_OP;
      r_hold_op <= OP_NOP;
      r_hold_rd <= '0;
      r_hold_rs <= '0;
      r_hold_pc <= '0;
    end else begin
      r_state <= w_state_next;
      if (flush) begin
        r_hold_op <= OP_NOP;
        r_hold_rd <= '0;
        r_hold_rs <= '0;
        r_hold_pc <= '0;
      end else if (w_hold_load) begin
        r_hold_op <= w_op;
        r_hold_rd <= w_rd;
        r_hold_rs <= w_rs;
        r_hold_pc <= bus.in_pc;
      end
    end
  end

  // A flush in the same cycle cancels the HLT hand-off.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_halted <= 1'b0;
    end else if (w_out_xfer && !flush && (w_out_uop.op == OP_HLT)) begin
      r_halted <= 1'b1;
    end
  end

  decode_uop_reg #(
    .W ($bits(uop_t))
  ) u_uop_reg (
    .clk     (CLK),
    .rst     (RST),
    .i_flush (flush),
    .i_load  (w_load),
    .i_data  (w_load_uop),
    .i_ready (bus.out_ready),
    .o_valid (w_out_valid),
    .o_data  (w_out_uop)
  );

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_op      = w_out_uop.op;
  assign bus.out_rd      = w_out_uop.rd;
  assign bus.out_rs      = w_out_uop.rs;
  assign bus.out_imm     = w_out_uop.imm;
  assign bus.out_pc      = w_out_uop.pc;
  assign bus.out_illegal = w_out_uop.illegal;
  assign halted          = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_decode_stage : vector table + scoreboard bench for decode_stage
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_decode_stage;

  logic CLK;
  logic RST;
  logic flush;
  logic halted;

  decode_stage_if #(.DATA_W(8), .REG_AW(2)) bus ();

  decode_stage #(.DATA_W(8), .REG_AW(2)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .flush  (flush),
    .halted (halted),
    .bus    (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm;
    logic [7:0] pc;
    logic       ill;
  } exp_t;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic       two;
    logic [7:0] pc0;
    logic [7:0] pc1;
    int         gap;
    exp_t       e;
  } vec_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard: every micro-op handed to execute must match the oldest expectation.
  always @(negedge CLK) begin
    if (!RST && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_uop", {28'h0, bus.out_op}, 32'hDEAD);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("uop_op",      {28'h0, bus.out_op},      {28'h0, e.op});
        chk("uop_rd",      {30'h0, bus.out_rd},      {30'h0, e.rd});
        chk("uop_rs",      {30'h0, bus.out_rs},      {30'h0, e.rs});
        chk("uop_imm",     {24'h0, bus.out_imm},     {24'h0, e.imm});
        chk("uop_pc",      {24'h0, bus.out_pc},      {24'h0, e.pc});
        chk("uop_illegal", {31'h0, bus.out_illegal}, {31'h0, e.ill});
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic [7:0] pc);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    bus.in_pc    = pc;
    while (!acc && n < 50) begin
      @(negedge CLK);
      acc = bus.in_ready;
      n++;
    end
    chk("byte_accepted", {31'h0, acc}, 32'h1);
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    @(posedge CLK);
    #1;
    chk("sb_drained", sbq.size(), 32'h0);
  endtask

  vec_t vecs[13];

  initial begin
    // b0, b1, two, pc0, pc1, gap, {op, rd, rs, imm, pc, ill}
    vecs[0]  = '{8'h26, 8'h00, 1'b0, 8'h00, 8'h00, 0, '{4'h2, 2'd1, 2'd2, 8'h00, 8'h00, 1'b0}};
    vecs[1]  = '{8'h64, 8'h5A, 1'b1, 8'h10, 8'h11, 3, '{4'h6, 2'd1, 2'd0, 8'h5A, 8'h10, 1'b0}};
    vecs[2]  = '{8'hC3, 8'h00, 1'b0, 8'h12, 8'h00, 0, '{4'hC, 2'd0, 2'd3, 8'h00, 8'h12, 1'b1}};
    vecs[3]  = '{8'h1B, 8'h00, 1'b0, 8'h13, 8'h00, 0, '{4'h1, 2'd2, 2'd3, 8'h00, 8'h13, 1'b0}};
    vecs[4]  = '{8'h80, 8'h44, 1'b1, 8'h14, 8'h15, 0, '{4'h8, 2'd0, 2'd0, 8'h44, 8'h14, 1'b0}};
    vecs[5]  = '{8'h7E, 8'h9C, 1'b1, 8'hFF, 8'h00, 1, '{4'h7, 2'd3, 2'd2, 8'h9C, 8'hFF, 1'b0}};
    vecs[6]  = '{8'h9D, 8'h00, 1'b0, 8'h01, 8'h00, 0, '{4'h9, 2'd3, 2'd1, 8'h00, 8'h01, 1'b0}};
    vecs[7]  = '{8'hA6, 8'h00, 1'b0, 8'h02, 8'h00, 0, '{4'hA, 2'd1, 2'd2, 8'h00, 8'h02, 1'b0}};
    vecs[8]  = '{8'h00, 8'h00, 1'b0, 8'h03, 8'h00, 0, '{4'h0, 2'd0, 2'd0, 8'h00, 8'h03, 1'b0}};
    vecs[9]  = '{8'h5F, 8'h00, 1'b0, 8'h04, 8'h00, 0, '{4'h5, 2'd3, 2'd3, 8'h00, 8'h04, 1'b0}};
    vecs[10] = '{8'h3C, 8'h00, 1'b0, 8'h05, 8'h00, 0, '{4'h3, 2'd3, 2'd0, 8'h00, 8'h05, 1'b0}};
    vecs[11] = '{8'hE1, 8'h00, 1'b0, 8'h06, 8'h00, 0, '{4'hE, 2'd0, 2'd1, 8'h00, 8'h06, 1'b1}};
    vecs[12] = '{8'h4B, 8'h00, 1'b0, 8'h07, 8'h00, 0, '{4'h4, 2'd2, 2'd3, 8'h00, 8'h07, 1'b0}};

    RST           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_byte   = 8'h00;
    bus.in_pc     = 8'h00;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_in_ready", {31'h0, bus.in_ready}, 32'h0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_out_valid", {31'h0, bus.out_valid},   32'h0);
    chk("rst_halted",    {31'h0, halted},          32'h0);
    chk("rst_out_op",    {28'h0, bus.out_op},      32'h0);
    chk("rst_out_pc",    {24'h0, bus.out_pc},      32'h0);
    chk("rst_out_imm",   {24'h0, bus.out_imm},     32'h0);
    chk("rst_illegal",   {31'h0, bus.out_illegal}, 32'h0);
    chk("rst_idle_ready",{31'h0, bus.in_ready},    32'h1);
    @(posedge CLK);
    #1;

    // Table-driven instruction stream
    for (int i = 0; i < 13; i++) begin
      sbq.push_back(vecs[i].e);
      send(vecs[i].b0, vecs[i].pc0);
      if (vecs[i].two) begin
        for (int g = 0; g < vecs[i].gap; g++) begin
          @(negedge CLK);
          chk("gap_no_uop", {31'h0, bus.out_valid}, 32'h0);
          @(posedge CLK);
          #1;
        end
        send(vecs[i].b1, vecs[i].pc1);
      end
    end
    drain();

    // Back-pressure: output must hold while execute stalls
    bus.out_ready = 1'b0;
    sbq.push_back('{4'h1, 2'd0, 2'd0, 8'h00, 8'h20, 1'b0});
    send(8'h10, 8'h20);
    sbq.push_back('{4'h2, 2'd0, 2'd0, 8'h00, 8'h21, 1'b0});
    fork
      send(8'h20, 8'h21);
      begin
        for (int k = 0; k < 4; k++) begin
          @(negedge CLK);
          chk("stall_valid",    {31'h0, bus.out_valid}, 32'h1);
          chk("stall_op",       {28'h0, bus.out_op},    32'h1);
          chk("stall_pc",       {24'h0, bus.out_pc},    32'h20);
          chk("stall_in_ready", {31'h0, bus.in_ready},  32'h0);
        end
        @(posedge CLK);
        #1;
        bus.out_ready = 1'b1;
        @(negedge CLK);
        chk("unstall_in_ready", {31'h0, bus.in_ready}, 32'h1);
      end
    join
    drain();

    // Flush between JMP opcode and its operand
    send(8'h70, 8'h30);
    flush = 1'b1;
    @(negedge CLK);
    chk("flush_in_ready", {31'h0, bus.in_ready}, 32'h0);
    @(posedge CLK);
    #1;
    flush = 1'b0;
    sbq.push_back('{4'h0, 2'd0, 2'd0, 8'h00, 8'h40, 1'b0});
    send(8'h00, 8'h40);
    drain();

    // HLT cancelled by flush before it transfers
    bus.out_ready = 1'b0;
    send(8'hF0, 8'h50);
    @(negedge CLK);
    chk("hlt_pend_valid", {31'h0, bus.out_valid}, 32'h1);
    chk("hlt_pend_op",    {28'h0, bus.out_op},    32'hF);
    chk("hlt_pend_ready", {31'h0, bus.in_ready},  32'h0);
    @(posedge CLK);
    #1;
    flush = 1'b1;
    @(posedge CLK);
    #1;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge CLK);
    chk("hlt_flush_valid",  {31'h0, bus.out_valid}, 32'h0);
    chk("hlt_flush_halted", {31'h0, halted},        32'h0);
    chk("hlt_flush_ready",  {31'h0, bus.in_ready},  32'h1);
    @(posedge CLK);
    #1;

    // HLT retires: halted one cycle after transfer, frozen until reset
    sbq.push_back('{4'hF, 2'd0, 2'd1, 8'h00, 8'h51, 1'b0});
    send(8'hF1, 8'h51);
    @(negedge CLK);
    chk("hlt_xfer_halted", {31'h0, halted}, 32'h0);
    @(negedge CLK);
    chk("halted_set",       {31'h0, halted},        32'h1);
    chk("halted_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("halted_in_ready",  {31'h0, bus.in_ready},  32'h0);
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'h26;
    bus.in_pc    = 8'h52;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("halted_frozen", {31'h0, bus.in_ready}, 32'h0);
      chk("halted_no_uop", {31'h0, bus.out_valid}, 32'h0);
    end
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    chk("rst2_in_ready", {31'h0, bus.in_ready}, 32'h0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("rst2_halted",   {31'h0, halted},        32'h0);
    chk("rst2_in_ready", {31'h0, bus.in_ready},  32'h1);
    chk("rst2_valid",    {31'h0, bus.out_valid}, 32'h0);
    chk("sb_empty_end",  sbq.size(),             32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, required finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Second pipeline stage of the ay8 core; sits directly downstream of the fetch stage.
- Consumes the stream of instruction bytes fetch reads from IMemory (with each byte's PC) over a valid/ready handshake.
- Assembles one- and two-byte instructions, decodes them into a registered micro-op for the execute stage, flags illegal opcodes, and supports flush (taken branch) and halt.

Parameters:
- DATA_W, 8, instruction byte / immediate / PC width
- REG_AW, 2, register-index width (4 GPRs)

Ports:
- CLK  in  1  core clock, all state updates on posedge
- RST  in  1  synchronous, active-high reset
- in_valid  in  1  fetch presents a byte
- in_ready  out  1  decode accepts byte this cycle
- in_byte  in  DATA_W  fetched instruction byte
- in_pc  in  DATA_W  address of in_byte
- flush  in  1  execute redirect; discard all in-flight decode state
- out_valid  out  1  micro-op valid
- out_ready  in  1  execute accepts micro-op
- out_op  out  4  opcode class (byte[7:4])
- out_rd  out  REG_AW  byte[3:2]
- out_rs  out  REG_AW  byte[1:0]
- out_imm  out  DATA_W  second byte for two-byte ops, else 0
- out_pc  out  DATA_W  PC of opcode byte
- out_illegal  out  1  opcode class undefined
- halted  out  1  HLT retired; stage frozen

Behaviour:
- Decided interface: one clock, CLK. Reset RST is synchronous and active-high.
- Reset values:
  - out_valid=0; out_op/rd/rs/imm/pc=0; out_illegal=0; halted=0; state=S_OP; hold registers=0.
- Opcode map (byte[7:4]):
  - One-byte: 0 NOP, 1 MOV, 2 ADD, 3 SUB, 4 AND, 5 OR, 9 LD, A ST, F HLT.
  - Two-byte: 6 LDI, 7 JMP, 8 JZ.
  - B–E are illegal, treated as one-byte, out_illegal=1.
- Handshake:
  - Byte transfer = in_valid && in_ready.
  - Micro-op transfer = out_valid && out_ready.
  - in_ready = !RST && !flush && !halted && !hlt_pending && (!out_valid || out_ready).
  - hlt_pending = out_valid && out_op==F.
- States:
  - S_OP: awaiting opcode byte. On transfer:
    - One-byte op: load output regs (imm=0), out_valid=1 next cycle, stay S_OP.
    - Two-byte op: latch op/rd/rs/pc into hold regs, go S_IMM; out_valid is unchanged by this event.
  - S_IMM: awaiting operand byte. On transfer: load output from hold regs with imm=in_byte, out_valid=1, go S_OP.
- out_valid update:
  - Clears on micro-op transfer unless reloaded the same cycle.
  - Back-to-back loading is allowed, giving one micro-op per cycle for one-byte ops.
- Latency: 1 cycle from the last byte's transfer to out_valid.
- Output regs are stable while out_valid && !out_ready.
- Flush (priority over everything except RST):
  - Next cycle: out_valid=0, state=S_OP, hold regs dropped.
  - No byte is accepted in the flush cycle.
  - halted is not affected.
- Halt:
  - halted sets the cycle after the HLT micro-op transfers.
  - Clears only on RST.
  - A flush while HLT is still pending (not yet transferred) cancels it; halted stays 0.
- Boundary cases:
  - Opcode byte transferred while out_valid && out_ready holds the previous micro-op: both events take effect.
  - Two-byte op split by fetch bubbles: S_IMM waits indefinitely.
  - PC wrap 0xFF→0x00 between opcode and immediate: no special handling; out_pc is the opcode PC.

Decomposition:
- Package ay8_pkg:
  - typedef enum logic [3:0] opcode_t (NOP..HLT)
  - typedef struct packed uop_t {op, rd, rs, imm, pc, illegal}
  - function is_two_byte(opcode_t)
  - function is_legal(opcode_t)
  - decode state enum {S_OP, S_IMM}
- One sub-module: decode_uop_reg, the output register plus valid/ready holding logic, reusable by later stages.

Test Plan:
- Reset, then bytes 0x26 (ADD rd=1 rs=2) at pc 0x00 with out_ready=1 → next cycle out_valid=1, op=2, rd=1, rs=2, imm=0, pc=0x00.
- 0x64, 0x5A (LDI r1,#0x5A) at pc 0x10/0x11 with a 3-cycle gap between bytes → single micro-op op=6, rd=1, imm=0x5A, pc=0x10; no output during the gap.
- Hold out_ready=0 for 4 cycles after 0x10 → out fields stable; in_ready=0; following byte 0x20 is accepted only in the cycle out_ready rises.
- Send 0x70, then assert flush before the operand byte → no micro-op; next 0x00 decodes as NOP with its own pc.
- Opcode 0xC3 → out_illegal=1, op=0xC, one-byte; the following byte decodes normally.
- 0xF0 (HLT) accepted, then flush before out_ready → halted=0. Repeat without flush → halted=1 one cycle after transfer; in_ready stays 0 until RST=1 clears it.
